// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit, 7-segment display.
// New digit values reach the display only at frame boundaries, so one frame never
// mixes old and new digits. Optional build macro SEG7_DIM_EN adds the dim_level
// brightness input, which shortens each anode's on-time within its slot.
//
// Handshake FSM states:
//   state   | meaning
//   ST_IDLE | no capture request outstanding
//   ST_PEND | load seen; capture at the next frame end
module seg7_scan_ctrl #(
    parameter int PRESCALE = 50000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
`ifdef SEG7_DIM_EN
    input  logic [2:0]  dim_level,
`endif
    output logic        load_ack,
    output logic        frame_tick,
    output logic        AN0,
    output logic        AN1,
    output logic        AN2,
    output logic        AN3,
    output logic [6:0]  LEDout
);

    localparam int PCNT_W = $clog2(PRESCALE);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } hs_state_t;

    hs_state_t         state;
    hs_state_t         state_nxt;
    logic              capture;

    logic [PCNT_W-1:0] pcnt;
    logic [1:0]        idx;
    logic              slot_tick;
    logic              frame_end;

    logic [15:0]       sh_digits;
    logic [3:0]        sh_blank;

    logic [3:0]        cur_digit;
    logic              an_on;
    logic [3:0]        an_nxt;
    logic [6:0]        led_nxt;
    logic [3:0]        an_q;
    logic [6:0]        led_q;

    assign slot_tick = (pcnt == PCNT_LAST);
    assign frame_end = slot_tick && (idx == 2'd3);
    assign cur_digit = sh_digits[{idx, 2'b00} +: 4];

    // Hex to active-low segments, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h01;
            4'h1:    s = 7'h4F;
            4'h2:    s = 7'h12;
            4'h3:    s = 7'h06;
            4'h4:    s = 7'h4C;
            4'h5:    s = 7'h24;
            4'h6:    s = 7'h20;
            4'h7:    s = 7'h0F;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h04;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h60;
            4'hC:    s = 7'h31;
            4'hD:    s = 7'h42;
            4'hE:    s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    // Slot prescaler, digit index and the registered frame pulse.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= 2'd0;
            frame_tick <= 1'b0;
        end else begin
            pcnt       <= slot_tick ? '0 : pcnt + PCNT_W'(1);
            idx        <= slot_tick ? idx + 2'd1 : idx;
            frame_tick <= frame_end;
        end
    end

    // Handshake next state; a load arriving on the frame_end cycle is captured at once.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        if (frame_end && (state == ST_PEND || load)) begin
            capture   = 1'b1;
            state_nxt = ST_IDLE;
        end else if (load) begin
            state_nxt = ST_PEND;
        end
    end

    // Handshake state, shadow registers and the ack pulse.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            sh_digits <= 16'h0000;
            sh_blank  <= 4'hF;
            load_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            load_ack <= capture;
            if (capture) begin
                sh_digits <= digits_in;
                sh_blank  <= blank_in;
            end
        end
    end

`ifdef SEG7_DIM_EN
    logic [31:0] thr;
    assign thr = (32'(dim_level) + 32'd1) * 32'(PRESCALE / 8);
`endif

    // Anode enable: pcnt==0 is a dead cycle so the previous digit cannot ghost.
    always_comb begin
        an_on = (pcnt != '0) && !sh_blank[idx];
`ifdef SEG7_DIM_EN
        an_on = an_on && (32'(pcnt) < thr);
`endif
        an_nxt  = an_on ? ~(4'b0001 << idx) : 4'hF;
        led_nxt = an_on ? seg_decode(cur_digit) : 7'h7F;
    end

    // Registered output stage.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            an_q  <= 4'hF;
            led_q <= 7'h7F;
        end else begin
            an_q  <= an_nxt;
            led_q <= led_nxt;
        end
    end

    assign AN0    = an_q[0];
    assign AN1    = an_q[1];
    assign AN2    = an_q[2];
    assign AN3    = an_q[3];
    assign LEDout = led_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit, 7-segment display on the lab board. It drives AN0..AN3 and LEDout.
- Digit values and blanks are captured through a load/ack handshake into shadow registers, only at frame boundaries, so a frame never shows a mix of old and new digits.
- Upstream lab logic supplies the digit values. This block owns all anode sequencing and hex-to-segment decode.

Parameters:
- PRESCALE, 50000: clk_in cycles per digit slot. Must be ≥4; with SEG7_DIM_EN, must also be a multiple of 8. Benches use 4 or 8.

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- digits_in  input  16  digit3..digit0 nibbles; [3:0] is digit0 → AN0
- blank_in  input  4  per-digit blank; bit n blanks digit n
- load  input  1  capture request; hold digits_in/blank_in stable until load_ack
- load_ack  output  1  one-cycle pulse; capture done
- frame_tick  output  1  one-cycle pulse at end of each 4-slot frame
- AN0..AN3  output  1 each  anode enables, active-low
- LEDout  output  7  segments, active-low; [6]=a … [0]=g
- dim_level  input  3  brightness; present only with SEG7_DIM_EN

Behaviour:
- Reset values: pcnt=0, idx=0, shadow digits=0, shadow blank=4'hF, pending=0, AN0..AN3=1, LEDout=7'h7F, load_ack=0, frame_tick=0.
- Prescaler pcnt:
  - Counts 0..PRESCALE-1, then wraps.
  - slot_tick = (pcnt==PRESCALE-1).
- Digit index idx:
  - Advances on slot_tick; wraps 3→0.
  - Internal frame_end = slot_tick && idx==3.
  - frame_tick is registered frame_end: high for one cycle after the wrap.
- Handshake:
  - load=1 sets pending.
  - On a frame_end cycle with (pending || load), shadow ← {digits_in, blank_in} sampled that cycle, and pending clears.
  - load_ack=1 on the following cycle only.
  - load held past ack with pending already clear starts a new request; requesters deassert load in the ack cycle.
  - load asserted in the frame_end cycle itself is captured immediately.
  - Worst-case ack latency: 4*PRESCALE+1 cycles.
- Output stage: registered, one-cycle latency from (pcnt, idx, shadow).
  - Anode idx is driven low iff pcnt!=0 (dead cycle suppresses ghosting) and shadow blank[idx]==0 (and, with the macro, the dim condition holds).
  - The other anodes are high.
  - LEDout = decode(shadow digit[idx]) whenever an anode is active; otherwise 7'h7F.
  - At most one anode is low in any cycle.
- Decode, active-low, hex digit:pattern:
  - 0:01  1:4F  2:12  3:06  4:4C  5:24  6:20  7:0F
  - 8:00  9:04  A:08  b:60  C:31  d:42  E:30  F:38
- Reset mid-frame or mid-handshake:
  - All state returns to reset values on the next edge.
  - A pending load is dropped; the requester must re-assert load.
- Full duty without the macro: each anode is low PRESCALE-1 of every 4*PRESCALE cycles.

Optional Feature:
- Macro: SEG7_DIM_EN.
- Defined:
  - dim_level port exists.
  - thr = (dim_level+1)*(PRESCALE/8).
  - Anode additionally requires pcnt < thr.
  - Anode is low for thr-1 cycles per slot; dim_level=7 equals full duty.
  - dim_level is sampled every cycle, with no frame alignment.
- Undefined: port absent; full duty as above.

Test Plan:
- Reset (PRESCALE=4): rst high 3 cycles, then release → AN0..AN3=1, LEDout=7'h7F, load_ack=0. All anodes stay high for a full frame, because blank resets to 4'hF.
- Load 16'h1234, blank_in=0 mid-frame → load_ack pulse exactly 1 cycle after the next frame_end. Next frame:
  - AN0 low with LEDout=7'h4C.
  - AN1 low with 7'h06.
  - AN2 low with 7'h12.
  - AN3 low with 7'h4F.
  - Each anode low 3 cycles, then 1 all-high dead cycle.
- blank_in=4'b0100 loaded with 16'hABCD → AN2 never low. LEDout=7'h7F during slot 2. AN0/AN1/AN3 show 7'h42/7'h31/7'h08.
- load asserted exactly on the frame_end cycle with 16'h0F0F → shadow updates that edge, load_ack high the next cycle, new digits shown from slot 0 of the next frame.
- rst asserted during slot 2 while a load is pending → next cycle all anodes high, LEDout=7'h7F, no load_ack ever issued for that request.
- SEG7_DIM_EN, PRESCALE=8:
  - dim_level=1 → each active anode low exactly 1 cycle per slot.
  - dim_level=7 → low 7 cycles.
  - dim_level=3 → low 3 cycles.
